// File: rtl/cpu0_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// cpu0_mem_arbiter_pkg
// Shared definitions for the CPU0 memory arbiter and its byte-lane helper:
// FSM state encoding, transaction owner codes, byte-enable constants and
// the alignment predicate used when a request is granted.
// ---------------------------------------------------------------------------
package cpu0_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_B0   = 4'b1000;

  // Word accesses must sit on a 4-byte boundary; byte accesses never fault.
  function automatic logic isMisaligned(input logic isWord, input logic [1:0] lowAddr);
    return isWord && (lowAddr != 2'b00);
  endfunction

endpackage

// File: rtl/cpu0_byte_lane.sv
// ---------------------------------------------------------------------------
// cpu0_byte_lane
// Combinational big-endian byte-lane steering for CPU0 byte accesses.
// Lane 0 (lowest address) is bits [31:24] of the memory word.
//
// Ports:
//   i_byte   : 1 = byte access, 0 = word access
//   i_lane   : byte offset within the word (addr[1:0])
//   i_wdata  : store data from the core (byte in [7:0] when i_byte)
//   i_mrdata : word read back from memory
//   o_be     : memory byte enables, bit3 = lowest-address byte
//   o_wdata  : memory write data (byte replicated to all lanes)
//   o_rdata  : load data for the core, zero-extended for byte loads
// ---------------------------------------------------------------------------
module cpu0_byte_lane
  import cpu0_mem_arbiter_pkg::*;
(
  input  logic        i_byte,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_mrdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  // Word accesses pass straight through; byte accesses select one lane for
  // reads and replicate the byte on writes so the enables alone pick the lane.
  always_comb begin
    o_be    = BE_WORD;
    o_wdata = i_wdata;
    o_rdata = i_mrdata;
    if (i_byte) begin
      o_be    = BE_B0 >> i_lane;
      o_wdata = {4{i_wdata[7:0]}};
      case (i_lane)
        2'd0:    o_rdata = {24'b0, i_mrdata[31:24]};
        2'd1:    o_rdata = {24'b0, i_mrdata[23:16]};
        2'd2:    o_rdata = {24'b0, i_mrdata[15:8]};
        default: o_rdata = {24'b0, i_mrdata[7:0]};
      endcase
    end
  end

endmodule

// File: rtl/cpu0_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cpu0_mem_arbiter
// Shares the single CPU0 memory between the instruction-fetch port and the
// data port. One req/ack transaction at a time, data normally has priority,
// a starvation counter lets a waiting fetch through every STARVE_LIMIT data
// grants. Misaligned word accesses are answered with an error without a
// memory cycle; a memory that never answers is aborted after TIMEOUT cycles.
//
// Ports:
//   clock, reset_n          : rising-edge clock, synchronous active-low reset
//   i_req/i_addr            : fetch request (word address)
//   i_ack/i_err/i_rdata     : fetch completion pulse, error flag, word
//   d_req/d_we/d_byte       : data request, store flag, byte-access flag
//   d_addr/d_wdata          : data address and store data
//   d_ack/d_err/d_rdata     : data completion pulse, error flag, load data
//   m_req/m_we/m_be         : memory request, write, big-endian byte enables
//   m_addr/m_wdata          : word-aligned memory address, write data
//   m_ack/m_rdata           : memory completion and read word
// ---------------------------------------------------------------------------
module cpu0_mem_arbiter
  import cpu0_mem_arbiter_pkg::*;
#(
  parameter int AW           = 32,
  parameter int TIMEOUT      = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic          i_err,
  output logic [31:0]   i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic          d_byte,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_ack,
  output logic          d_err,
  output logic [31:0]   d_rdata,
  output logic          m_req,
  output logic          m_we,
  output logic [3:0]    m_be,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  input  logic          m_ack,
  input  logic [31:0]   m_rdata
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  state_t          r_state;
  state_t          w_nextState;
  logic            r_owner;
  logic            r_we;
  logic            r_byte;
  logic [1:0]      r_lane;
  logic [3:0]      r_be;
  logic [AW-1:0]   r_addr;
  logic [31:0]     r_wdata;
  logic [TW-1:0]   r_tcnt;
  logic [SW-1:0]   r_starve;
  logic            r_iErr;
  logic            r_dErr;
  logic [31:0]     r_iRdata;
  logic [31:0]     r_dRdata;

  logic            w_anyReq;
  logic            w_fetchStarved;
  logic            w_pickD;
  logic [AW-1:0]   w_selAddr;
  logic            w_selByte;
  logic            w_misaligned;
  logic            w_timeout;
  logic            w_laneByte;
  logic [1:0]      w_laneIdx;
  logic [3:0]      w_laneBe;
  logic [31:0]     w_laneWdata;
  logic [31:0]     w_laneRdata;
  logic [31:0]     w_capData;

  // Arbitration: data wins unless a fetch has waited through STARVE_LIMIT
  // data grants. Only a byte-wide data access escapes the alignment check.
  assign w_anyReq       = i_req | d_req;
  assign w_fetchStarved = i_req && (r_starve == SW'(STARVE_LIMIT));
  assign w_pickD        = d_req && !w_fetchStarved;
  assign w_selAddr      = w_pickD ? d_addr : i_addr;
  assign w_selByte      = w_pickD && d_byte;
  assign w_misaligned   = isMisaligned(!w_selByte, w_selAddr[1:0]);
  assign w_timeout      = (r_tcnt == TW'(TIMEOUT - 1));

  // The lane steering is shared: in IDLE it shapes the request being latched,
  // afterwards it steers the returning read word of the latched access.
  assign w_laneByte = (r_state == IDLE) ? w_selByte : r_byte;
  assign w_laneIdx  = (r_state == IDLE) ? w_selAddr[1:0] : r_lane;
  assign w_capData  = r_we ? 32'd0 : w_laneRdata;

  cpu0_byte_lane u_byteLane (
    .i_byte   (w_laneByte),
    .i_lane   (w_laneIdx),
    .i_wdata  (d_wdata),
    .i_mrdata (m_rdata),
    .o_be     (w_laneBe),
    .o_wdata  (w_laneWdata),
    .o_rdata  (w_laneRdata)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. A misaligned grant skips the memory cycle entirely.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_anyReq) begin
          w_nextState = w_misaligned ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (m_ack || w_timeout) begin
          w_nextState = RESP;
        end
      end
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Transaction datapath: latch the granted request in IDLE, count wait
  // cycles in BUSY, and load the owner's response registers on completion.
  // Response registers only change when a new response is produced so they
  // hold their value between ack pulses.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_owner  <= OWN_I;
      r_we     <= 1'b0;
      r_byte   <= 1'b0;
      r_lane   <= 2'b00;
      r_be     <= 4'b0000;
      r_addr   <= '0;
      r_wdata  <= 32'd0;
      r_tcnt   <= '0;
      r_iErr   <= 1'b0;
      r_dErr   <= 1'b0;
      r_iRdata <= 32'd0;
      r_dRdata <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_owner <= w_pickD ? OWN_D : OWN_I;
            r_tcnt  <= '0;
            if (w_misaligned) begin
              if (w_pickD) begin
                r_dRdata <= 32'd0;
                r_dErr   <= 1'b1;
              end else begin
                r_iRdata <= 32'd0;
                r_iErr   <= 1'b1;
              end
            end else begin
              r_we    <= w_pickD && d_we;
              r_byte  <= w_selByte;
              r_lane  <= w_selAddr[1:0];
              r_be    <= w_laneBe;
              r_addr  <= {w_selAddr[AW-1:2], 2'b00};
              r_wdata <= w_pickD ? w_laneWdata : 32'd0;
            end
          end
        end
        BUSY: begin
          r_tcnt <= r_tcnt + TW'(1);
          if (m_ack || w_timeout) begin
            if (r_owner == OWN_D) begin
              r_dRdata <= m_ack ? w_capData : 32'd0;
              r_dErr   <= !m_ack;
            end else begin
              r_iRdata <= m_ack ? w_capData : 32'd0;
              r_iErr   <= !m_ack;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Starvation counter: counts data grants that bypassed a waiting fetch,
  // saturates at the limit, and clears on a fetch grant or an idle fetch port.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_starve <= '0;
    end else if (!i_req) begin
      r_starve <= '0;
    end else if ((r_state == IDLE) && w_anyReq) begin
      if (!w_pickD) begin
        r_starve <= '0;
      end else if (r_starve != SW'(STARVE_LIMIT)) begin
        r_starve <= r_starve + SW'(1);
      end
    end
  end

  assign i_ack   = (r_state == RESP) && (r_owner == OWN_I);
  assign d_ack   = (r_state == RESP) && (r_owner == OWN_D);
  assign i_err   = r_iErr;
  assign d_err   = r_dErr;
  assign i_rdata = r_iRdata;
  assign d_rdata = r_dRdata;
  assign m_req   = (r_state == BUSY);
  assign m_we    = r_we;
  assign m_be    = r_be;
  assign m_addr  = r_addr;
  assign m_wdata = r_wdata;

endmodule

// File: tb/tb_cpu0_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cpu0_mem_arbiter
// Directed self-checking bench for cpu0_mem_arbiter with default parameters
// (AW=32, TIMEOUT=64, STARVE_LIMIT=4). Inputs change 1 time unit after a
// rising edge and outputs are observed at that same point.
// ---------------------------------------------------------------------------
module tb_cpu0_mem_arbiter;

  localparam int AW = 32;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ack;
  logic          i_err;
  logic [31:0]   i_rdata;
  logic          d_req;
  logic          d_we;
  logic          d_byte;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          d_ack;
  logic          d_err;
  logic [31:0]   d_rdata;
  logic          m_req;
  logic          m_we;
  logic [3:0]    m_be;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic          m_ack;
  logic [31:0]   m_rdata;

  int checks = 0;
  int errors = 0;

  cpu0_mem_arbiter #(.AW(AW), .TIMEOUT(64), .STARVE_LIMIT(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_ack   (i_ack),
    .i_err   (i_err),
    .i_rdata (i_rdata),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_byte  (d_byte),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_ack   (d_ack),
    .d_err   (d_err),
    .d_rdata (d_rdata),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_be    (m_be),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_ack   (m_ack),
    .m_rdata (m_rdata)
  );

  // 10-unit clock period.
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic stepClock();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic iReq, input logic [31:0] iAddr,
                               input logic dReq, input logic dWe, input logic dByte,
                               input logic [31:0] dAddr, input logic [31:0] dWdata);
    i_req   = iReq;
    i_addr  = iAddr;
    d_req   = dReq;
    d_we    = dWe;
    d_byte  = dByte;
    d_addr  = dAddr;
    d_wdata = dWdata;
  endtask

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  // Directed sequence.
  initial begin
    logic expOwnerI [10];
    int   reqCycles;
    bit   sawAck;

    expOwnerI = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    reset_n = 1'b0;
    m_ack   = 1'b0;
    m_rdata = 32'd0;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    stepClock();
    stepClock();

    $display("[TB] reset state");
    checkOutput("rst_m_req",   {31'd0, m_req},   32'd0);
    checkOutput("rst_i_ack",   {31'd0, i_ack},   32'd0);
    checkOutput("rst_d_ack",   {31'd0, d_ack},   32'd0);
    checkOutput("rst_m_be",    {28'd0, m_be},    32'd0);
    checkOutput("rst_m_addr",  m_addr,           32'd0);
    checkOutput("rst_i_rdata", i_rdata,          32'd0);
    reset_n = 1'b1;
    stepClock();

    $display("[TB] fetch 0x10 with zero-wait memory");
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    stepClock();
    checkOutput("f_m_req",  {31'd0, m_req}, 32'd1);
    checkOutput("f_m_addr", m_addr,         32'h10);
    checkOutput("f_m_be",   {28'd0, m_be},  32'hF);
    checkOutput("f_m_we",   {31'd0, m_we},  32'd0);
    checkOutput("f_i_ack0", {31'd0, i_ack}, 32'd0);
    m_ack   = 1'b1;
    m_rdata = 32'h08100037;
    stepClock();
    m_ack = 1'b0;
    checkOutput("f_i_ack",   {31'd0, i_ack}, 32'd1);
    checkOutput("f_i_rdata", i_rdata,        32'h08100037);
    checkOutput("f_i_err",   {31'd0, i_err}, 32'd0);
    checkOutput("f_d_ack",   {31'd0, d_ack}, 32'd0);
    checkOutput("f_m_req2",  {31'd0, m_req}, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    stepClock();
    checkOutput("f_i_ack_end", {31'd0, i_ack}, 32'd0);
    checkOutput("f_i_hold",    i_rdata,        32'h08100037);

    $display("[TB] byte store 0xAB at 0x22");
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 32'h22, 32'h000000AB);
    stepClock();
    checkOutput("sb_m_addr",  m_addr,         32'h20);
    checkOutput("sb_m_be",    {28'd0, m_be},  32'h2);
    checkOutput("sb_m_wdata", m_wdata,        32'hABABABAB);
    checkOutput("sb_m_we",    {31'd0, m_we},  32'd1);
    m_ack   = 1'b1;
    m_rdata = 32'h55555555;
    stepClock();
    m_ack = 1'b0;
    checkOutput("sb_d_ack",   {31'd0, d_ack}, 32'd1);
    checkOutput("sb_d_rdata", d_rdata,        32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    stepClock();

    $display("[TB] byte load at 0x21");
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 32'h21, 32'd0);
    stepClock();
    checkOutput("lb_m_be",   {28'd0, m_be}, 32'h4);
    checkOutput("lb_m_we",   {31'd0, m_we}, 32'd0);
    checkOutput("lb_m_addr", m_addr,        32'h20);
    m_ack   = 1'b1;
    m_rdata = 32'h11223344;
    stepClock();
    m_ack = 1'b0;
    checkOutput("lb_d_ack",   {31'd0, d_ack}, 32'd1);
    checkOutput("lb_d_rdata", d_rdata,        32'h00000022);
    checkOutput("lb_d_err",   {31'd0, d_err}, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    stepClock();

    $display("[TB] memory timeout on word load 0x40");
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'h40, 32'd0);
    stepClock();
    reqCycles = 0;
    sawAck    = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (m_req) reqCycles++;
      if (d_ack) begin
        sawAck = 1'b1;
        break;
      end
      stepClock();
    end
    checkOutput("to_saw_ack",  {31'd0, sawAck}, 32'd1);
    checkOutput("to_req_cyc",  reqCycles,       32'd64);
    checkOutput("to_m_req",    {31'd0, m_req},  32'd0);
    checkOutput("to_d_err",    {31'd0, d_err},  32'd1);
    checkOutput("to_d_rdata",  d_rdata,         32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    stepClock();

    $display("[TB] misaligned accesses");
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'h102, 32'd0);
    stepClock();
    checkOutput("ma_d_ack", {31'd0, d_ack}, 32'd1);
    checkOutput("ma_d_err", {31'd0, d_err}, 32'd1);
    checkOutput("ma_m_req", {31'd0, m_req}, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    stepClock();
    checkOutput("ma_m_req2", {31'd0, m_req}, 32'd0);
    applyStimulus(1'b1, 32'h0F, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    stepClock();
    checkOutput("mf_i_ack",   {31'd0, i_ack}, 32'd1);
    checkOutput("mf_i_err",   {31'd0, i_err}, 32'd1);
    checkOutput("mf_i_rdata", i_rdata,        32'd0);
    checkOutput("mf_m_req",   {31'd0, m_req}, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    stepClock();

    $display("[TB] starvation with both ports requesting");
    applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h200, 32'd0);
    for (int g = 0; g < 10; g++) begin
      stepClock();
      checkOutput($sformatf("st_addr_%0d", g), m_addr,
                  expOwnerI[g] ? 32'h100 : 32'h200);
      m_ack   = 1'b1;
      m_rdata = 32'h1000 + g;
      stepClock();
      m_ack = 1'b0;
      checkOutput($sformatf("st_i_ack_%0d", g), {31'd0, i_ack}, {31'd0, expOwnerI[g]});
      checkOutput($sformatf("st_d_ack_%0d", g), {31'd0, d_ack}, {31'd0, !expOwnerI[g]});
      stepClock();
    end
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    stepClock();

    $display("[TB] reset during BUSY");
    applyStimulus(1'b1, 32'h30, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    stepClock();
    checkOutput("rb_m_req_busy", {31'd0, m_req}, 32'd1);
    reset_n = 1'b0;
    stepClock();
    checkOutput("rb_m_req", {31'd0, m_req}, 32'd0);
    checkOutput("rb_i_ack", {31'd0, i_ack}, 32'd0);
    checkOutput("rb_d_ack", {31'd0, d_ack}, 32'd0);
    reset_n = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    m_ack   = 1'b1;
    m_rdata = 32'hDEADBEEF;
    stepClock();
    m_ack = 1'b0;
    checkOutput("rb_late_i_ack", {31'd0, i_ack}, 32'd0);
    checkOutput("rb_late_m_req", {31'd0, m_req}, 32'd0);
    stepClock();
    checkOutput("rb_late_i_ack2", {31'd0, i_ack}, 32'd0);
    applyStimulus(1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    stepClock();
    checkOutput("rb_new_m_req",  {31'd0, m_req}, 32'd1);
    checkOutput("rb_new_m_addr", m_addr,         32'h44);
    m_ack   = 1'b1;
    m_rdata = 32'hCAFEF00D;
    stepClock();
    m_ack = 1'b0;
    checkOutput("rb_new_i_ack",   {31'd0, i_ack}, 32'd1);
    checkOutput("rb_new_i_rdata", i_rdata,        32'hCAFEF00D);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    stepClock();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu0_mem_arbiter.md
Name: cpu0_mem_arbiter

Overview:
Shares the single CPU0 memory between the instruction-fetch port and the data (load/store/stack) port of a multi-cycle CPU0 core. Each access is one transaction on a req/ack memory bus with variable latency. The block also handles big-endian byte-lane steering for LDB/STB/LBR/SBR/PUSHB/POPB, alignment checks and a no-response timeout. It sits between the core and the memory model/SRAM.

Parameters:
AW, 32, address width
TIMEOUT, 64, m_ack wait cycles before the access is aborted with an error (>=2)
STARVE_LIMIT, 4, consecutive data grants after which a pending fetch wins the next arbitration (>=1)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  synchronous active-low reset
i_req  in  1  fetch request; held with i_addr stable until i_ack
i_addr  in  AW  fetch address (word)
i_ack  out  1  one-cycle completion pulse for fetch
i_err  out  1  valid with i_ack: misaligned or timeout
i_rdata  out  32  fetched word, valid with i_ack
d_req  in  1  data request; held with fields stable until d_ack
d_we  in  1  1=store, 0=load
d_byte  in  1  1=byte access, 0=word access
d_addr  in  AW  data address
d_wdata  in  32  store data (byte in [7:0] when d_byte)
d_ack  out  1  one-cycle completion pulse for data
d_err  out  1  valid with d_ack
d_rdata  out  32  load data, zero-extended for byte loads
m_req  out  1  memory request, held until m_ack or timeout
m_we  out  1  memory write
m_be  out  4  byte enables, bit3 = byte at lowest address (big-endian)
m_addr  out  AW  word-aligned address
m_wdata  out  32  write data
m_ack  in  1  memory completion, sampled only while m_req=1
m_rdata  in  32  read word, valid with m_ack

Behaviour:
- Reset (reset_n=0 at a rising edge): state IDLE. All outputs 0, timeout and starvation counters 0. Reset mid-transaction drops m_req at that edge and emits no ack. m_ack seen outside BUSY is ignored.
- FSM states: IDLE, BUSY, RESP.
- IDLE, no request: stay in IDLE.
- IDLE, with request: select an owner.
  - d_req wins over i_req, unless i_req=1 and starve_cnt==STARVE_LIMIT; then fetch wins.
  - starve_cnt increments on each data grant while i_req=1, saturating at STARVE_LIMIT.
  - starve_cnt clears on a fetch grant or when i_req=0.
- IDLE, alignment check on the selected request:
  - Word access (any fetch, or data with d_byte=0) with addr[1:0]!=0 is misaligned.
  - Misaligned: go to RESP with err=1, rdata=0. No memory cycle is issued.
  - Aligned: latch owner, we, be, address and wdata. Set m_req=1 and go to BUSY.
- BUSY: m_* held constant; tcnt increments each cycle.
  - m_ack=1: capture the steered read data, err=0, go to RESP.
  - tcnt==TIMEOUT-1 without m_ack: m_req=0, err=1, rdata=0, go to RESP.
- RESP: the owner's ack=1 for exactly one cycle, together with rdata/err. The non-owner's ack stays 0. Next state is IDLE.
- Requester rule: deassert req (or present a new request) at the edge where ack is sampled. req=1 in the cycle after ack is treated as a new request.
- Latency: req sampled in IDLE at edge t. m_req is high in cycle t+1. With zero-wait memory (m_ack in t+1), ack is high in cycle t+2 and the block is back in IDLE at t+3.
- The misaligned path acks in cycle t+1.
- Byte steering, lane k = d_addr[1:0]:
  - m_addr = {addr[AW-1:2],2'b00}
  - m_be = 4'b1000>>k; word access uses m_be=4'b1111
  - m_wdata = byte replicated into all 4 lanes
  - d_rdata = {24'b0, m_rdata[31-8k -: 8]}
- Write transactions return d_rdata=0.
- i_rdata/d_rdata/err hold their last value between acks; only the ack pulse qualifies them.

Decomposition:
- Shared header cpu0_bus.vh:
  - state encodings IDLE=2'd0, BUSY=2'd1, RESP=2'd2
  - owner codes OWN_I=1'b0, OWN_D=1'b1
  - byte-enable constants BE_WORD=4'b1111, BE_B0=4'b1000
- One sub-module: cpu0_byte_lane. It is combinational and maps (d_byte, addr[1:0], wdata, m_rdata) to (m_be, m_wdata, steered rdata). It is reused later by the cache.

Test Plan:
- Fetch only, i_addr=0x10, memory acks at once with m_rdata=0x08100037 -> m_req in t+1, i_ack in t+2, i_rdata=0x08100037, i_err=0.
- d_req store d_byte=1, d_addr=0x22, d_wdata=0x000000AB -> m_addr=0x20, m_be=4'b0010, m_wdata=0xABABABAB, m_we=1. Byte load at 0x21 with m_rdata=0x11223344 -> d_rdata=0x00000022.
- i_req and d_req held continuously, 1-cycle memory -> grant order D,D,D,D,I,D,D,D,D,I (STARVE_LIMIT=4); never two consecutive I grants while d_req=1.
- Word load d_addr=0x102 -> d_ack+d_err one cycle after sampling, m_req never asserted. Fetch at 0x0F -> i_err=1, i_rdata=0.
- Memory never acks -> m_req high for exactly TIMEOUT cycles, then drops; next cycle d_ack=1, d_err=1, d_rdata=0.
- reset_n=0 during BUSY -> m_req=0 and all acks 0 after that edge. A late m_ack after release is ignored, and a new i_req is served normally.
